// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches, buffers {pc, insn}
// responses for decode and applies control-flow redirects from execute.
module fetch_unit #(
   parameter int                DWIDTH     = 32,
   parameter int                AWIDTH     = 32,
   parameter logic [AWIDTH-1:0] BASEADDR   = 32'h0100_0000,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o
);
   localparam int            CW      = $clog2(FIFO_DEPTH + 1);
   localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   logic [AWIDTH-1:0] r_pc;
   logic [AWIDTH-1:0] r_rsp_pc;
   logic [CW-1:0]     r_out;
   logic [CW-1:0]     r_drop;
   logic [CW-1:0]     r_count;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [AWIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [DWIDTH-1:0] r_fifo_insn [FIFO_DEPTH];

   logic              w_credit;
   logic              w_req_fire;
   logic              w_rsp;
   logic              w_push;
   logic              w_pop;
   logic [AWIDTH-1:0] w_target;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Credit counts only registered state so a request never depends on same-cycle pops.
   assign w_credit         = ({1'b0, r_out} + {1'b0, r_count}) < DEPTH_W;
   assign imem_req_valid_o = rst && !redirect_i && w_credit;
   assign imem_addr_o      = rst ? r_pc : '0;
   assign valid_o          = rst && (r_count != '0);
   assign pc_o             = rst ? r_fifo_pc[r_rptr] : '0;
   assign insn_o           = rst ? r_fifo_insn[r_rptr] : '0;

   assign w_req_fire = imem_req_valid_o && imem_req_ready_i;
   assign w_rsp      = rst && imem_rsp_valid_i;
   assign w_push     = w_rsp && (r_drop == '0) && !redirect_i;
   assign w_pop      = valid_o && ready_i && !redirect_i;
   assign w_target   = {redirect_pc_i[AWIDTH-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc     <= BASEADDR;
         r_rsp_pc <= BASEADDR;
         r_out    <= '0;
         r_drop   <= '0;
         r_count  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
      end else begin
         r_out <= r_out + CW'(w_req_fire) - CW'(w_rsp);
         if (redirect_i) begin
            // Everything still in flight is stale; the same-cycle response is dropped here.
            r_pc     <= w_target;
            r_rsp_pc <= w_target;
            r_drop   <= r_out - CW'(w_rsp);
            r_count  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
         end else begin
            if (w_req_fire)
               r_pc <= r_pc + AWIDTH'(4);
            if (w_rsp && (r_drop != '0))
               r_drop <= r_drop - CW'(1);
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + AWIDTH'(4);
               r_wptr   <= f_inc(r_wptr);
            end
            if (w_pop)
               r_rptr <= f_inc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wptr]   <= r_rsp_pc;
         r_fifo_insn[r_wptr] <= imem_rsp_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (r_out <= CW'(FIFO_DEPTH));
         assert (r_drop <= r_out);
         assert (!imem_rsp_valid_i || (r_out != '0));
         assert (!(w_push && (r_count == CW'(FIFO_DEPTH))))
            else $fatal(1, "fetch_unit: instruction buffer overflow");
      end
   end
endmodule
